irq_ctrl: RTL

//  Interrupt controller behind the decoder's irq_cs strobe (address 0x7FFF).

---
 rtl/irq_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches rising edges on up to 7 sources, gates them with a software mask
// and drives the 6502's active-low IRQ line. Define IRQ_CTRL_SYNC_EN to synchronise src first.
module irq_ctrl #(
  parameter int unsigned N_SRC = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             rwb,
  input  logic             wr_stb,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  input  logic [N_SRC-1:0] src,
  output logic             irq_n
);

  logic [N_SRC-1:0] src_s;
  logic [N_SRC-1:0] src_d_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ack;
  logic             irq_n_q;
  logic             wr;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src;
`endif

  assign wr   = cs & ~rwb & wr_stb;
  assign rise = src_s & ~src_d_q;

  always_comb begin
    ack    = '0;
    mask_d = mask_q;
    if (wr) begin
      if (data_in[7]) begin
        mask_d = data_in[N_SRC-1:0];
      end else begin
        ack = data_in[N_SRC-1:0];
      end
    end
    // A new edge beats a simultaneous ack so no event is lost.
    pending_d = rise | (pending_q & ~ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_d_q   <= '1;
      pending_q <= '0;
      mask_q    <= '0;
      irq_n_q   <= 1'b1;
    end else begin
      src_d_q   <= src_s;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_n_q   <= ~|(pending_q & mask_q);
    end
  end

  assign irq_n = irq_n_q;

  always_comb begin
    data_out = 8'h00;
    if (cs && rwb) begin
      data_out[7]         = ~irq_n_q;
      data_out[N_SRC-1:0] = pending_q;
    end
  end

endmodule
